uart_txrx: RTL and testbench
============================

# uart_txrx

Parametrised full-duplex UART core with independent transmitter and receiver, valid/ready byte interfaces, configurable frame format, and error reporting. It sits between a local bus or FIFO and the off-chip serial pins. It replaces the fixed 8-bit, one-bit-per-clock UART with a divided bit clock, a mid-bit-sampling receiver, and flow control.

## Interface
- CLK_DIV, 16: clk cycles per serial bit; legal range is 4 or more.
- DATA_BITS, 8: data bits per frame; legal range is 5..9.
- PARITY, PAR_NONE: one of PAR_NONE, PAR_ODD, PAR_EVEN (uart_pkg::parity_e).
- STOP_BITS, 1: stop bits per frame, 1 or 2.
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- tx_data  in  DATA_BITS  byte to send.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  transmitter can accept a byte.
- tx  out  1  serial output; idles high.
- rx  in  1  serial input; asynchronous.
- rx_data  out  DATA_BITS  received byte.
- rx_valid  out  1  rx_data holds an unread byte.
- rx_ready  in  1  consumer takes rx_data.
- parity_err  out  1  one-cycle pulse: parity mismatch; the frame is dropped.
- frame_err  out  1  one-cycle pulse: first stop bit sampled 0; the frame is dropped.
- overrun  out  1  one-cycle pulse: a good frame completed while rx_valid=1; the new frame is dropped.

## Operation
- Frame format: start bit (0), then DATA_BITS data bits LSB first, then an optional parity bit, then STOP_BITS stop bits (1).
  - Odd parity: the parity bit makes the total count of ones odd.
  - Even parity: the parity bit makes the total count of ones even.
- TX FSM states: TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP.
  - tx_ready=1 only in TX_IDLE.
  - A handshake occurs when tx_valid and tx_ready are both 1. The handshake latches tx_data and moves the FSM to TX_START.
  - Each state holds its bit for CLK_DIV cycles. A bit index counts data bits, and a stop counter counts stop bits.
  - TX_PARITY is skipped when PARITY=PAR_NONE.
- RX path: rx passes through a 2-flop synchronizer.
- RX FSM states: RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK.
  - RX_IDLE: when the synchronized rx is 0, go to RX_START.
  - RX_START: after CLK_DIV/2 cycles (floor), resample rx.
    - If rx=1, it was a false start; return to RX_IDLE.
    - If rx=0, continue. Each following bit is sampled CLK_DIV cycles after the previous sample.
  - RX_STOP: samples only the first stop bit. The second stop bit is not checked.
    - If the stop bit is 1 and parity is good, deliver the frame and return to RX_IDLE.
    - If the stop bit is 0, pulse frame_err and go to RX_BREAK.
    - If parity is bad, pulse parity_err and return to RX_IDLE.
    - If both errors occur, pulse both.
  - RX_BREAK: wait for the synchronized rx to return to 1, then go to RX_IDLE.
- Output buffer: one entry.
  - Delivery sets rx_valid=1 and loads rx_data.
  - rx_valid and rx_ready both 1 clears rx_valid on the next edge.
  - If delivery and consumption happen in the same cycle, the new frame is loaded and rx_valid stays 1. No overrun is flagged.
  - A delivery while rx_valid=1 with no consume keeps the old data and pulses overrun.
- TX and RX are fully independent; loopback works only through an external wire.

## Timing
- Reset values: tx=1, tx_ready=1, rx_valid=0, rx_data=0, parity_err=0, frame_err=0, overrun=0. Both FSMs are in IDLE and all counters are 0.
- Reset mid-frame aborts immediately: tx returns to 1 on the next edge, and any partial RX frame is discarded.
- TX timing, with the handshake at edge N:
  - tx=0 and tx_ready=0 from N+1.
  - Bit k occupies cycles N+1+k·CLK_DIV through N+(k+1)·CLK_DIV.
  - tx_ready returns to 1 one cycle after the last stop bit ends.
- Frame length is F = CLK_DIV·(1 + DATA_BITS + (PARITY≠NONE) + STOP_BITS) cycles. Back-to-back bytes are therefore spaced F+1 cycles apart.
- tx_valid may drop before the handshake without effect. tx_data is ignored after the handshake.
- RX latency: rx_valid rises 3 cycles after the mid-stop-bit sample point on the raw rx pin. This is 2 cycles of synchronizer plus 1 register stage.
- Error pulses align with the cycle in which rx_valid would have risen.

## Structure
- uart_pkg holds:
  - the parity_e enum;
  - the tx_state_e and rx_state_e enums;
  - a function computing the parity bit from data and parity_e.
- Sub-module uart_bit_timer is instantiated twice, once for TX and once for RX.
  - Inputs: a load input with a preset value (CLK_DIV or CLK_DIV/2).
  - Output: a one-cycle tick when the count expires.
- The top level contains the two FSMs, the shift registers, and the synchronizer.

## Test plan
- Basic TX (CLK_DIV=4, DATA_BITS=8, PAR_EVEN, STOP_BITS=1): send 0xA5.
  - Required: tx carries 0,1,0,1,0,0,1,0,1,0(parity),1, each bit for 4 cycles.
  - tx_ready is low for 44 cycles.
- Loopback: connect tx to rx and send 0x00, 0xFF, 0x3C back-to-back with rx_ready=1.
  - Required: rx_data is 0x00, 0xFF, 0x3C in order, with no error pulses.
- Overrun: hold rx_ready=0 and loop back 0x11 then 0x22.
  - Required: overrun pulses once, and rx_data stays 0x11.
  - Then raise rx_ready: rx_valid drops the next cycle.
- Errors (PAR_ODD): inject 0x01 with a wrong parity bit.
  - Required: parity_err pulses and rx_valid stays 0.
  - Inject a frame with stop=0 followed by 20 low cycles: frame_err pulses once, and no new start is detected until rx returns high.
- False start (CLK_DIV=16): drive a 3-cycle low glitch on rx.
  - Required: no rx_valid and no error pulses; the RX FSM returns to IDLE.
- Reset mid-frame: assert reset during data bit 3 of a TX frame and an RX frame.
  - Required: tx=1 and tx_ready=1 on the following cycle, and no rx_valid.
  - A subsequent frame is then received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the uart_txrx core: frame parity modes, FSM states,
// and the parity-bit helper used by both directions.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5
  } rx_state_e;

  // Data is zero-extended to 9 bits, so unused bits do not affect parity.
  function automatic logic par_bit(
    input logic [8:0] data,
    input parity_e    mode
  );
    logic p;
    p = 1'b0;
    case (mode)
      PAR_ODD:  p = ~^data;
      PAR_EVEN: p = ^data;
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Down-counter for serial bit timing: load a preset, tick once when it
// runs out, then rest at zero until the next load.
module uart_bit_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] preset,
  output logic         tick
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= preset;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tick = (cnt == W'(1));

endmodule

// File: rtl/uart_txrx.sv
// Full-duplex UART: divided-clock transmitter and mid-bit-sampling
// receiver with a one-entry output buffer and error pulses.
module uart_txrx
  import uart_pkg::*;
#(
  parameter int      CLK_DIV   = 16,
  parameter int      DATA_BITS = 8,
  parameter parity_e PARITY    = PAR_NONE,
  parameter int      STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int TW = $clog2(CLK_DIV + 1);
  localparam logic [TW-1:0] FULL = TW'(CLK_DIV);
  localparam logic [TW-1:0] HALF = TW'(CLK_DIV / 2);
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic HAS_PAR = (PARITY != PAR_NONE);

  tx_state_e            tx_state;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic [3:0]           tx_idx;
  logic                 tx_stop;
  logic                 tx_tick;
  logic                 tx_load;
  logic                 tx_last_stop;

  assign tx_ready     = (tx_state == TX_IDLE);
  assign tx_last_stop = (tx_state == TX_STOP) && (tx_stop == LAST_STOP);
  assign tx_load      = (tx_ready && tx_valid)
                     || (tx_tick && !tx_ready && !tx_last_stop);

  uart_bit_timer #(.W(TW)) tx_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (tx_load),
    .preset (FULL),
    .tick   (tx_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx       <= 1'b1;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_idx   <= '0;
      tx_stop  <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_valid) begin
            tx_shift <= tx_data;
            tx_par   <= par_bit(9'(tx_data), PARITY);
            tx       <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_tick) begin
            tx       <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_idx   <= '0;
            tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (tx_tick) begin
            if (tx_idx == LAST_BIT) begin
              if (HAS_PAR) begin
                tx       <= tx_par;
                tx_state <= TX_PARITY;
              end else begin
                tx       <= 1'b1;
                tx_stop  <= 1'b0;
                tx_state <= TX_STOP;
              end
            end else begin
              tx       <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
              tx_idx   <= tx_idx + 4'd1;
            end
          end
        end
        TX_PARITY: begin
          if (tx_tick) begin
            tx       <= 1'b1;
            tx_stop  <= 1'b0;
            tx_state <= TX_STOP;
          end
        end
        TX_STOP: begin
          if (tx_tick) begin
            if (tx_last_stop) tx_state <= TX_IDLE;
            else tx_stop <= tx_stop + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  rx_state_e            rx_state;
  logic                 rx_s1;
  logic                 rx_s2;
  logic [DATA_BITS-1:0] rx_shift;
  logic [3:0]           rx_idx;
  logic                 rx_par;
  logic                 rx_tick;
  logic                 rx_load;
  logic [TW-1:0]        rx_preset;
  logic                 par_ok;
  logic                 deliver;

  assign rx_load = (rx_state == RX_IDLE && !rx_s2)
                || (rx_tick && ((rx_state == RX_START && !rx_s2)
                             || rx_state == RX_DATA
                             || rx_state == RX_PARITY));
  assign rx_preset = (rx_state == RX_IDLE) ? HALF : FULL;
  assign par_ok    = !HAS_PAR
                  || (rx_par == par_bit(9'(rx_shift), PARITY));
  assign deliver   = (rx_state == RX_STOP) && rx_tick && rx_s2 && par_ok;

  uart_bit_timer #(.W(TW)) rx_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (rx_load),
    .preset (rx_preset),
    .tick   (rx_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_shift <= '0;
      rx_idx   <= '0;
      rx_par   <= 1'b0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (!rx_s2) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_tick) begin
            rx_idx   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_tick) begin
            rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
            if (rx_idx == LAST_BIT)
              rx_state <= HAS_PAR ? RX_PARITY : RX_STOP;
            else
              rx_idx <= rx_idx + 4'd1;
          end
        end
        RX_PARITY: begin
          if (rx_tick) begin
            rx_par   <= rx_s2;
            rx_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_tick) rx_state <= rx_s2 ? RX_IDLE : RX_BREAK;
        end
        RX_BREAK: begin
          if (rx_s2) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Sync flops reset high so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_s1      <= rx;
      rx_s2      <= rx_s1;
      parity_err <= (rx_state == RX_STOP) && rx_tick && !par_ok;
      frame_err  <= (rx_state == RX_STOP) && rx_tick && !rx_s2;
      overrun    <= deliver && rx_valid && !rx_ready;
      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= rx_shift;
          rx_valid <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_txrx.sv
// Bench for uart_txrx: a fast even-parity instance (loopback, overrun,
// reset) and a slow odd-parity two-stop instance (errors, glitches).
module tb_uart_txrx;
  import uart_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset0, reset1;
  logic [7:0] tx_data0, tx_data1, rx_data0, rx_data1;
  logic       tx_valid0, tx_valid1, tx_ready0, tx_ready1;
  logic       tx0, tx1, rx0, rx1, rx_valid0, rx_valid1;
  logic       rx_ready0, rx_ready1;
  logic       perr0, perr1, ferr0, ferr1, ovr0, ovr1;
  logic       loop0, loop1, drv0, drv1;

  assign rx0 = loop0 ? tx0 : drv0;
  assign rx1 = loop1 ? tx1 : drv1;

  uart_txrx #(
    .CLK_DIV(4), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1)
  ) u0 (
    .clk(clk), .reset(reset0), .tx_data(tx_data0), .tx_valid(tx_valid0),
    .tx_ready(tx_ready0), .tx(tx0), .rx(rx0), .rx_data(rx_data0),
    .rx_valid(rx_valid0), .rx_ready(rx_ready0), .parity_err(perr0),
    .frame_err(ferr0), .overrun(ovr0)
  );

  uart_txrx #(
    .CLK_DIV(16), .DATA_BITS(8), .PARITY(PAR_ODD), .STOP_BITS(2)
  ) u1 (
    .clk(clk), .reset(reset1), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .tx(tx1), .rx(rx1), .rx_data(rx_data1),
    .rx_valid(rx_valid1), .rx_ready(rx_ready1), .parity_err(perr1),
    .frame_err(ferr1), .overrun(ovr1)
  );

  int checks = 0;
  int failures = 0;
  int pe0 = 0, fe0 = 0, ov0 = 0, dlv0 = 0;
  int pe1 = 0, fe1 = 0, ov1 = 0, dlv1 = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Frame as transmitted bit sequence, bit j = j-th bit on the wire.
  function automatic logic [15:0] frame0(input logic [7:0] d);
    logic [15:0] f;
    f     = 16'(d) << 1;
    f[9]  = ($countones(d) % 2) == 1;
    f[10] = 1'b1;
    return f;
  endfunction

  function automatic logic [15:0] frame1(input logic [7:0] d);
    logic [15:0] f;
    f     = 16'(d) << 1;
    f[9]  = ($countones(d) % 2) == 0;
    f[10] = 1'b1;
    f[11] = 1'b1;
    return f;
  endfunction

  function automatic logic rdy(input int u);
    return (u == 1) ? tx_ready1 : tx_ready0;
  endfunction

  function automatic logic txo(input int u);
    return (u == 1) ? tx1 : tx0;
  endfunction

  task automatic send(input int u, input logic [7:0] d,
                      input logic [15:0] fr);
    int nb, dv, k;
    nb = (u == 1) ? 12 : 11;
    dv = (u == 1) ? 16 : 4;
    k = 0;
    while (!rdy(u) && k < 1000) begin
      step();
      k++;
    end
    chk("tx_ready_wait", rdy(u), 1);
    if (u == 1) begin
      tx_data1 = d; tx_valid1 = 1'b1;
    end else begin
      tx_data0 = d; tx_valid0 = 1'b1;
    end
    step();
    tx_valid0 = 1'b0;
    tx_valid1 = 1'b0;
    tx_data0 = 8'($urandom);
    tx_data1 = 8'($urandom);
    for (int j = 0; j < nb * dv; j++) begin
      chk("tx_bit", txo(u), fr[j / dv]);
      chk("tx_ready_busy", rdy(u), 0);
      step();
    end
    chk("tx_ready_after", rdy(u), 1);
  endtask

  task automatic inject(input logic [15:0] bits, input int ncell);
    for (int j = 0; j < ncell * 16; j++) begin
      drv1 = bits[j / 16];
      step();
    end
  endtask

  always @(negedge clk) begin
    if (!reset0) begin
      if (perr0) pe0++;
      if (ferr0) fe0++;
      if (ovr0) ov0++;
      if (rx_valid0 && rx_ready0) begin
        dlv0++;
        if (q0.size() == 0) begin
          checks++; failures++;
          $display("FAIL rx0_extra actual=%0h required=none", rx_data0);
        end else chk("rx0_data", rx_data0, q0.pop_front());
      end
    end
    if (!reset1) begin
      if (perr1) pe1++;
      if (ferr1) fe1++;
      if (ovr1) ov1++;
      if (rx_valid1 && rx_ready1) begin
        dlv1++;
        if (q1.size() == 0) begin
          checks++; failures++;
          $display("FAIL rx1_extra actual=%0h required=none", rx_data1);
        end else chk("rx1_data", rx_data1, q1.pop_front());
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0]  d;
    logic [15:0] fr;
  } vec_t;
  vec_t tv[6];

  logic [7:0] d;
  int b_pe, b_fe, b_ov, b_dlv;

  initial begin
    tv[0] = '{8'hA5, 16'b00000_1_0_10100101_0};
    tv[1] = '{8'h00, 16'b00000_1_0_00000000_0};
    tv[2] = '{8'hFF, 16'b00000_1_0_11111111_0};
    tv[3] = '{8'h3C, 16'b00000_1_0_00111100_0};
    tv[4] = '{8'h01, 16'b00000_1_1_00000001_0};
    tv[5] = '{8'h07, 16'b00000_1_1_00000111_0};

    reset0 = 1'b1; reset1 = 1'b1;
    tx_data0 = '0; tx_data1 = '0; tx_valid0 = 1'b0; tx_valid1 = 1'b0;
    rx_ready0 = 1'b1; rx_ready1 = 1'b1;
    loop0 = 1'b1; loop1 = 1'b0; drv0 = 1'b1; drv1 = 1'b1;
    repeat (3) step();
    reset0 = 1'b0; reset1 = 1'b0;
    step();
    chk("rst_tx0", tx0, 1);
    chk("rst_tx_ready0", tx_ready0, 1);
    chk("rst_rx_valid0", rx_valid0, 0);
    chk("rst_rx_data0", rx_data0, 0);
    chk("rst_errs0", {perr0, ferr0, ovr0}, 0);
    chk("rst_tx1", tx1, 1);
    chk("rst_tx_ready1", tx_ready1, 1);
    chk("rst_rx_valid1", rx_valid1, 0);
    chk("rst_errs1", {perr1, ferr1, ovr1}, 0);

    for (int i = 0; i < 6; i++) begin
      q0.push_back(tv[i].d);
      send(0, tv[i].d, tv[i].fr);
    end
    repeat (20) step();
    chk("table_drain0", q0.size(), 0);
    chk("table_dlv0", dlv0, 6);

    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      q0.push_back(d);
      send(0, d, frame0(d));
    end
    repeat (20) step();
    chk("rand_drain0", q0.size(), 0);
    chk("loop_errs0", pe0 + fe0 + ov0, 0);

    rx_ready0 = 1'b0;
    b_ov = ov0;
    q0.push_back(8'h11);
    send(0, 8'h11, frame0(8'h11));
    send(0, 8'h22, frame0(8'h22));
    repeat (12) step();
    chk("ovr_pulses", ov0 - b_ov, 1);
    chk("ovr_valid", rx_valid0, 1);
    chk("ovr_data", rx_data0, 8'h11);
    rx_ready0 = 1'b1;
    step();
    chk("ovr_drop", rx_valid0, 0);
    chk("ovr_drain", q0.size(), 0);

    b_dlv = dlv0;
    while (!tx_ready0) step();
    tx_data0 = 8'h5A; tx_valid0 = 1'b1;
    step();
    tx_valid0 = 1'b0;
    repeat (17) step();
    reset0 = 1'b1;
    step();
    chk("rst_mid_tx", tx0, 1);
    chk("rst_mid_ready", tx_ready0, 1);
    chk("rst_mid_rxv", rx_valid0, 0);
    reset0 = 1'b0;
    repeat (60) step();
    chk("rst_mid_nodlv", dlv0 - b_dlv, 0);
    q0.push_back(8'h96);
    send(0, 8'h96, frame0(8'h96));
    repeat (20) step();
    chk("rst_mid_after", q0.size(), 0);
    chk("rst_mid_errs", pe0 + fe0, 0);

    b_pe = pe1; b_fe = fe1; b_dlv = dlv1;
    inject({4'b0, 2'b11, 1'b1, 8'h01, 1'b0}, 12);
    drv1 = 1'b1;
    repeat (40) step();
    chk("perr_pulse", pe1 - b_pe, 1);
    chk("perr_no_ferr", fe1 - b_fe, 0);
    chk("perr_no_dlv", dlv1 - b_dlv, 0);
    chk("perr_rxv", rx_valid1, 0);

    b_pe = pe1; b_fe = fe1; b_dlv = dlv1;
    inject({5'b0, 1'b0, 1'b1, 8'h55, 1'b0}, 11);
    drv1 = 1'b0;
    repeat (20) step();
    drv1 = 1'b1;
    repeat (60) step();
    chk("ferr_pulse", fe1 - b_fe, 1);
    chk("ferr_no_perr", pe1 - b_pe, 0);
    chk("ferr_no_dlv", dlv1 - b_dlv, 0);
    q1.push_back(8'hC3);
    inject(frame1(8'hC3), 12);
    drv1 = 1'b1;
    repeat (20) step();
    chk("ferr_recover", q1.size(), 0);

    b_pe = pe1; b_fe = fe1; b_dlv = dlv1;
    drv1 = 1'b0;
    repeat (3) step();
    drv1 = 1'b1;
    repeat (40) step();
    chk("glitch_no_dlv", dlv1 - b_dlv, 0);
    chk("glitch_no_err", (pe1 - b_pe) + (fe1 - b_fe), 0);
    q1.push_back(8'h4E);
    inject(frame1(8'h4E), 12);
    drv1 = 1'b1;
    repeat (20) step();
    chk("glitch_recover", q1.size(), 0);

    loop1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      q1.push_back(d);
      send(1, d, frame1(d));
    end
    repeat (30) step();
    loop1 = 1'b0;
    chk("rand_drain1", q1.size(), 0);
    chk("total_ov0", ov0, 1);
    chk("total_pe0", pe0, 0);
    chk("total_fe0", fe0, 0);
    chk("total_pe1", pe1, 1);
    chk("total_fe1", fe1, 1);
    chk("total_ov1", ov1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
